// File: rtl/fmesh_destp_encoder_if.sv
// Valid/ready stream bundle for the fmesh destination-port encoder:
// request side carries endpoint addresses, response side carries coded ports.
interface fmesh_destp_encoder_if #(
  parameter int EAw = 7,
  parameter int PLw = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [EAw-1:0] dest_e_addr;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     dest_port_coded;
  logic [PLw-1:0] endp_localp_num;
  logic           addr_err;

  modport slave (
    input  in_valid, dest_e_addr, out_ready,
    output in_ready, out_valid, dest_port_coded, endp_localp_num, addr_err
  );

  modport master (
    output in_valid, dest_e_addr, out_ready,
    input  in_ready, out_valid, dest_port_coded, endp_localp_num, addr_err
  );
endinterface

// File: rtl/fmesh_destp_encoder.sv
// Two-stage elastic route-encode stage: S1 compares the destination against this
// router, S2 registers the coded {x,y,a,b} port, local-port index and error flag.
module fmesh_destp_encoder #(
  parameter int    T1         = 4,
  parameter int    T2         = 4,
  parameter int    T3         = 2,
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    EAw        = 7,
  parameter int    RAw        = 4,
  parameter int    PLw        = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RAw-1:0]       current_r_addr,
  fmesh_destp_encoder_if.slave strm
);

  localparam int EXw = (T1 > 1) ? $clog2(T1) : 1;
  localparam int EYw = (T2 > 1) ? $clog2(T2) : 1;
  localparam int EPw = EAw - EXw - EYw;

  localparam bit          ADAPTIVE = (ROUTE_TYPE != "DETERMINISTIC");
  localparam logic [31:0] X_MAX    = 32'(T1 - 1);
  localparam logic [31:0] Y_MAX    = 32'(T2 - 1);
  localparam logic [31:0] P_MAX    = 32'(T3 + 3);

  localparam logic [EPw-1:0] P_EAST  = EPw'(1);
  localparam logic [EPw-1:0] P_NORTH = EPw'(2);
  localparam logic [EPw-1:0] P_WEST  = EPw'(3);
  localparam logic [EPw-1:0] P_SOUTH = EPw'(4);

  // Returns {addr_err, code[3:0], localp}; the first matching rule wins.
  function automatic logic [PLw+4:0] encode_f(
    input logic           err,
    input logic           dx_ne,
    input logic           xp,
    input logic           dy_ne,
    input logic           yn,
    input logic [EPw-1:0] ep
  );
    logic [3:0]     code;
    logic [PLw-1:0] lp;
    logic           e;
    code = 4'b0000;
    lp   = {PLw{1'b0}};
    e    = 1'b0;
    if (err) begin
      e = 1'b1;
    end else if (ADAPTIVE && dx_ne && dy_ne) begin
      code = {xp, yn, 2'b11};
    end else if (dx_ne) begin
      code = {xp, 3'b010};
    end else if (dy_ne) begin
      code = {1'b0, yn, 2'b01};
    end else begin
      // Same router: cardinal endpoint numbers sit on the mesh edge.
      case (ep)
        P_EAST:  code = 4'b1010;
        P_WEST:  code = 4'b0010;
        P_NORTH: code = 4'b0101;
        P_SOUTH: code = 4'b0001;
        default: lp   = PLw'(ep);
      endcase
    end
    return {e, code, lp};
  endfunction

  logic [EXw-1:0] ex_s;
  logic [EYw-1:0] ey_s;
  logic [EPw-1:0] ep_s;
  logic [EXw-1:0] cx_s;
  logic [EYw-1:0] cy_s;

  logic s2_adv_s;
  logic s1_adv_s;
  logic s1_push_s;
  logic s2_push_s;

  logic           s1_v_q,     s1_v_d;
  logic [EPw-1:0] s1_ep_q,    s1_ep_d;
  logic           s1_dx_ne_q, s1_dx_ne_d;
  logic           s1_xp_q,    s1_xp_d;
  logic           s1_dy_ne_q, s1_dy_ne_d;
  logic           s1_yn_q,    s1_yn_d;
  logic           s1_err_q,   s1_err_d;

  logic           s2_v_q,     s2_v_d;
  logic [3:0]     s2_code_q,  s2_code_d;
  logic [PLw-1:0] s2_lp_q,    s2_lp_d;
  logic           s2_err_q,   s2_err_d;

  logic [PLw+4:0] enc_s;

  assign ex_s = strm.dest_e_addr[EXw-1:0];
  assign ey_s = strm.dest_e_addr[EXw+EYw-1:EXw];
  assign ep_s = strm.dest_e_addr[EAw-1:EXw+EYw];
  assign cx_s = current_r_addr[EXw-1:0];
  assign cy_s = current_r_addr[RAw-1:EXw];

  // Elastic handshake: a stage advances when it is empty or its successor advances.
  always_comb begin
    s2_adv_s  = ~s2_v_q | strm.out_ready;
    s1_adv_s  = ~s1_v_q | s2_adv_s;
    s1_push_s = s1_adv_s & strm.in_valid;
    s2_push_s = s2_adv_s & s1_v_q;
  end

  // S1 next state: decode the address against the router sampled at load time.
  always_comb begin
    s1_v_d     = s1_adv_s  ? strm.in_valid : s1_v_q;
    s1_ep_d    = s1_push_s ? ep_s          : s1_ep_q;
    s1_dx_ne_d = s1_push_s ? (ex_s != cx_s) : s1_dx_ne_q;
    s1_xp_d    = s1_push_s ? (ex_s >  cx_s) : s1_xp_q;
    s1_dy_ne_d = s1_push_s ? (ey_s != cy_s) : s1_dy_ne_q;
    s1_yn_d    = s1_push_s ? (ey_s <  cy_s) : s1_yn_q;
    s1_err_d   = s1_push_s ? ((32'(ex_s) > X_MAX) | (32'(ey_s) > Y_MAX) | (32'(ep_s) > P_MAX))
                           : s1_err_q;
  end

  // S2 next state: encoded result loads only when S1 hands a request forward.
  always_comb begin
    enc_s     = encode_f(s1_err_q, s1_dx_ne_q, s1_xp_q, s1_dy_ne_q, s1_yn_q, s1_ep_q);
    s2_v_d    = s2_adv_s  ? s1_v_q                 : s2_v_q;
    s2_err_d  = s2_push_s ? enc_s[PLw+4]           : s2_err_q;
    s2_code_d = s2_push_s ? enc_s[PLw+3:PLw]       : s2_code_q;
    s2_lp_d   = s2_push_s ? enc_s[PLw-1:0]         : s2_lp_q;
  end

  // Pipeline registers; reset drops every in-flight request and clears the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s1_ep_q    <= {EPw{1'b0}};
      s1_dx_ne_q <= 1'b0;
      s1_xp_q    <= 1'b0;
      s1_dy_ne_q <= 1'b0;
      s1_yn_q    <= 1'b0;
      s1_err_q   <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_code_q  <= 4'b0000;
      s2_lp_q    <= {PLw{1'b0}};
      s2_err_q   <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_ep_q    <= s1_ep_d;
      s1_dx_ne_q <= s1_dx_ne_d;
      s1_xp_q    <= s1_xp_d;
      s1_dy_ne_q <= s1_dy_ne_d;
      s1_yn_q    <= s1_yn_d;
      s1_err_q   <= s1_err_d;
      s2_v_q     <= s2_v_d;
      s2_code_q  <= s2_code_d;
      s2_lp_q    <= s2_lp_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign strm.in_ready        = s1_adv_s;
  assign strm.out_valid       = s2_v_q;
  assign strm.dest_port_coded = s2_code_q;
  assign strm.endp_localp_num = s2_lp_q;
  assign strm.addr_err        = s2_err_q;

endmodule

// File: tb/tb_fmesh_destp_encoder.sv
// Directed bench: a deterministic and an adaptive encoder share one stimulus stream
// from router {cy,cx}={1,1}; results are compared with hand-computed codes.
module tb_fmesh_destp_encoder;

  logic       clk;
  logic       reset;
  logic [3:0] r_addr;

  fmesh_destp_encoder_if #(.EAw(7), .PLw(3)) if_det ();
  fmesh_destp_encoder_if #(.EAw(7), .PLw(3)) if_adp ();

  fmesh_destp_encoder #(.ROUTE_TYPE("DETERMINISTIC")) u_det (
    .clk(clk), .reset(reset), .current_r_addr(r_addr), .strm(if_det)
  );
  fmesh_destp_encoder #(.ROUTE_TYPE("ADAPTIVE")) u_adp (
    .clk(clk), .reset(reset), .current_r_addr(r_addr), .strm(if_adp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] addr;
    logic [3:0] code_det;
    logic [3:0] code_adp;
    logic [2:0] lp;
    logic       err;
  } vec_t;

  vec_t vecs [16];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input int ex, input int ey, input int ep,
                              input logic [3:0] cd, input logic [3:0] ca,
                              input int lp, input logic err);
    vec_t v;
    v.addr     = {3'(ep), 2'(ey), 2'(ex)};
    v.code_det = cd;
    v.code_adp = ca;
    v.lp       = 3'(lp);
    v.err      = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] a, input logic rdy);
    if_det.in_valid = v;  if_det.dest_e_addr = a;  if_det.out_ready = rdy;
    if_adp.in_valid = v;  if_adp.dest_e_addr = a;  if_adp.out_ready = rdy;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(if_det.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(if_det.in_ready),  32'd1);
    chk({tag, "_code"},      32'(if_det.dest_port_coded), 32'd0);
    chk({tag, "_localp"},    32'(if_det.endp_localp_num), 32'd0);
    chk({tag, "_err"},       32'(if_det.addr_err), 32'd0);
  endtask

  logic [15:0] lfsr;
  logic [3:0]  hold_code;
  logic [2:0]  hold_lp;
  logic        hold_err;
  logic        stalled;
  logic        push;
  logic        pop;
  int          sent;
  int          rcvd;
  int          occ;
  logic        saw_full;

  initial begin
    vecs[0]  = mk(3, 1, 0, 4'b1010, 4'b1010, 0, 1'b0);
    vecs[1]  = mk(0, 1, 0, 4'b0010, 4'b0010, 0, 1'b0);
    vecs[2]  = mk(1, 0, 0, 4'b0101, 4'b0101, 0, 1'b0);
    vecs[3]  = mk(1, 3, 0, 4'b0001, 4'b0001, 0, 1'b0);
    vecs[4]  = mk(1, 1, 0, 4'b0000, 4'b0000, 0, 1'b0);
    vecs[5]  = mk(1, 1, 5, 4'b0000, 4'b0000, 5, 1'b0);
    vecs[6]  = mk(1, 1, 1, 4'b1010, 4'b1010, 0, 1'b0);
    vecs[7]  = mk(1, 1, 4, 4'b0001, 4'b0001, 0, 1'b0);
    vecs[8]  = mk(1, 1, 2, 4'b0101, 4'b0101, 0, 1'b0);
    vecs[9]  = mk(1, 1, 3, 4'b0010, 4'b0010, 0, 1'b0);
    vecs[10] = mk(3, 3, 0, 4'b1010, 4'b1011, 0, 1'b0);
    vecs[11] = mk(0, 0, 0, 4'b0010, 4'b0111, 0, 1'b0);
    vecs[12] = mk(1, 1, 7, 4'b0000, 4'b0000, 0, 1'b1);
    vecs[13] = mk(2, 1, 0, 4'b1010, 4'b1010, 0, 1'b0);
    vecs[14] = mk(3, 3, 6, 4'b0000, 4'b0000, 0, 1'b1);
    vecs[15] = mk(0, 2, 5, 4'b0010, 4'b0011, 0, 1'b0);

    r_addr = 4'b0101;
    reset  = 1'b1;
    drive(1'b0, 7'd0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_idle("reset");

    // Single requests: nothing after the first edge, result after the second.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].addr, 1'b1);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(if_det.in_ready), 32'd1);
      @(posedge clk);
      #1;
      drive(1'b0, 7'h7f, 1'b1);
      chk($sformatf("v%0d_early_valid", i), 32'(if_det.out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(if_det.out_valid), 32'd1);
      chk($sformatf("v%0d_code_det", i), 32'(if_det.dest_port_coded), 32'(vecs[i].code_det));
      chk($sformatf("v%0d_code_adp", i), 32'(if_adp.dest_port_coded), 32'(vecs[i].code_adp));
      chk($sformatf("v%0d_localp", i), 32'(if_det.endp_localp_num), 32'(vecs[i].lp));
      chk($sformatf("v%0d_err", i), 32'(if_det.addr_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_adp_ab", i), 32'(if_det.dest_port_coded[1:0] == 2'b11), 32'd0);
    end

    // Backpressure stream of 8 with a pseudo-random out_ready pattern.
    @(negedge clk);
    drive(1'b0, 7'd0, 1'b1);
    @(negedge clk);
    lfsr     = 16'hACE1;
    sent     = 0;
    rcvd     = 0;
    occ      = 0;
    stalled  = 1'b0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid",  32'(if_det.out_valid), 32'd1);
        chk("stall_code",   32'(if_det.dest_port_coded), 32'(hold_code));
        chk("stall_localp", 32'(if_det.endp_localp_num), 32'(hold_lp));
        chk("stall_err",    32'(if_det.addr_err), 32'(hold_err));
      end
      drive(sent < 8, (sent < 8) ? vecs[sent].addr : 7'd0, lfsr[0]);
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      #1;
      chk("bp_in_ready", 32'(if_det.in_ready), 32'((occ < 2) || if_det.out_ready));
      if (occ == 2 && !if_det.out_ready) saw_full = 1'b1;
      push = if_det.in_valid && if_det.in_ready;
      pop  = if_det.out_valid && if_det.out_ready;
      if (pop) begin
        chk($sformatf("bp%0d_code", rcvd), 32'(if_det.dest_port_coded), 32'(vecs[rcvd].code_det));
        chk($sformatf("bp%0d_localp", rcvd), 32'(if_det.endp_localp_num), 32'(vecs[rcvd].lp));
        chk($sformatf("bp%0d_err", rcvd), 32'(if_det.addr_err), 32'(vecs[rcvd].err));
        rcvd++;
      end
      stalled   = if_det.out_valid && !if_det.out_ready;
      hold_code = if_det.dest_port_coded;
      hold_lp   = if_det.endp_localp_num;
      hold_err  = if_det.addr_err;
      occ = occ + int'(push) - int'(pop);
      if (push) sent++;
    end
    chk("bp_received", 32'(rcvd), 32'd8);
    chk("bp_saw_full", 32'(saw_full), 32'd1);

    // Fill the pipe while stalled, then reset with two requests in flight.
    @(negedge clk);
    drive(1'b1, vecs[0].addr, 1'b0);
    @(negedge clk);
    drive(1'b1, vecs[1].addr, 1'b0);
    @(negedge clk);
    drive(1'b0, 7'd0, 1'b0);
    #1;
    chk("full_in_ready", 32'(if_det.in_ready), 32'd0);
    chk("full_out_valid", 32'(if_det.out_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 7'd0, 1'b1);
    #1;
    chk_idle("midrst");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_stale%0d", k), 32'(if_det.out_valid), 32'd0);
    end

    // Router address changes after acceptance must not alter that request.
    @(negedge clk);
    drive(1'b1, vecs[10].addr, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 7'd0, 1'b1);
    r_addr = 4'b1111;
    @(posedge clk);
    #1;
    chk("raddr_valid", 32'(if_det.out_valid), 32'd1);
    chk("raddr_code", 32'(if_det.dest_port_coded), 32'(vecs[10].code_det));
    @(negedge clk);
    drive(1'b1, vecs[10].addr, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 7'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("raddr_new_code", 32'(if_det.dest_port_coded), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
